// File: rtl/clk_sel_ctrl.sv
// clk_sel_ctrl: qualifies two monitored clocks and drives the clock switch select
// with preference, failover on loss and a post-change holdoff.
module clk_sel_ctrl #(
  parameter int TIMEOUT     = 16,
  parameter int ALIVE_EDGES = 4,
  parameter int HOLDOFF     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_a_mon,
  input  logic clk_b_mon,
  input  logic pref_sel,
  output logic clk_sel,
  output logic a_alive,
  output logic b_alive,
  output logic switch_busy,
  output logic no_clk,
  output logic fail_evt
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int EW = $clog2(ALIVE_EDGES + 1);
  localparam int HW = $clog2(HOLDOFF + 1);
  typedef enum logic [1:0] {ST_A, ST_B, ST_HOLD} state_t;
  state_t state, state_n;
  logic [1:0] s1, s2, s3, rise, tout, alive, alive_d;
  logic p1, ps, want, sel_n, busy_n;
  logic [HW-1:0] hold_cnt, hold_n;
  assign rise = s2 & ~s3;
  assign a_alive = alive[0];
  assign b_alive = alive[1];
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic [WW-1:0] wd;
    logic [EW-1:0] ecnt;
    logic al;
    // a rise landing on the timeout cycle cancels the timeout
    assign tout[g] = !rise[g] && wd == WW'(TIMEOUT - 1);
    assign alive[g] = al;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        wd   <= '0;
        ecnt <= '0;
        al   <= 1'b0;
      end else begin
        wd   <= rise[g] ? '0 : (wd == WW'(TIMEOUT)) ? wd : wd + 1'b1;
        ecnt <= tout[g] ? '0 : (rise[g] && !al) ? ecnt + 1'b1 : ecnt;
        al   <= tout[g] ? 1'b0 : (rise[g] && !al && ecnt == EW'(ALIVE_EDGES - 1)) ? 1'b1 : al;
      end
  end
  assign want = alive[ps] ? ps : alive[!ps] ? !ps : clk_sel;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1          <= '0;
      s2          <= '0;
      s3          <= '0;
      p1          <= 1'b0;
      ps          <= 1'b0;
      alive_d     <= '0;
      no_clk      <= 1'b1;
      fail_evt    <= 1'b0;
      state       <= ST_A;
      clk_sel     <= 1'b0;
      hold_cnt    <= '0;
      switch_busy <= 1'b0;
    end else begin
      s1          <= {clk_b_mon, clk_a_mon};
      s2          <= s1;
      s3          <= s2;
      p1          <= pref_sel;
      ps          <= p1;
      alive_d     <= alive;
      no_clk      <= ~|alive;
      fail_evt    <= alive_d[clk_sel] & ~alive[clk_sel];
      state       <= state_n;
      clk_sel     <= sel_n;
      hold_cnt    <= hold_n;
      switch_busy <= busy_n;
    end
  always_comb begin
    state_n = state;
    sel_n   = clk_sel;
    hold_n  = hold_cnt;
    busy_n  = switch_busy;
    if (state == ST_HOLD) begin
      hold_n = hold_cnt - 1'b1;
      if (hold_cnt == '0) begin
        state_n = clk_sel ? ST_B : ST_A;
        hold_n  = '0;
        busy_n  = 1'b0;
      end
    end else if (want != clk_sel) begin
      state_n = ST_HOLD;
      sel_n   = want;
      hold_n  = HW'(HOLDOFF - 1);
      busy_n  = 1'b1;
    end
  end
endmodule

// File: tb/tb_clk_sel_ctrl.sv
// tb_clk_sel_ctrl: scenario tasks plus randomized clock/preference stimulus,
// checked against a cycle-indexed event model of the select controller.
module tb_clk_sel_ctrl;
  logic clk = 0, rst_n = 0, clk_a_mon = 0, clk_b_mon = 0, pref_sel = 0;
  logic clk_sel, a_alive, b_alive, switch_busy, no_clk, fail_evt;
  logic [5:0] obs, exp_v;
  int tests = 0, fails = 0;
  bit run_a = 0, run_b = 0, rnd = 0;
  int cnt_a = 0, cnt_b = 0, ea = 0, eb = 0;
  time last_rise_a = 0;

  clk_sel_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clk_a_mon(clk_a_mon), .clk_b_mon(clk_b_mon),
    .pref_sel(pref_sel), .clk_sel(clk_sel), .a_alive(a_alive), .b_alive(b_alive),
    .switch_busy(switch_busy), .no_clk(no_clk), .fail_evt(fail_evt)
  );

  always #5 clk = ~clk;
  assign obs = {clk_sel, a_alive, b_alive, switch_busy, no_clk, fail_evt};

  // A: 10-cycle period; B: 13-cycle period; random phases 2..7 cycles when rnd
  initial forever begin
    @(negedge clk);
    if (run_a) begin
      if (cnt_a <= 1) begin
        clk_a_mon = ~clk_a_mon;
        if (clk_a_mon) begin ea++; last_rise_a = $time; end
        cnt_a = rnd ? int'($urandom_range(2, 7)) : 5;
      end else cnt_a--;
    end
    if (run_b) begin
      if (cnt_b <= 1) begin
        clk_b_mon = ~clk_b_mon;
        if (clk_b_mon) eb++;
        cnt_b = rnd ? int'($urandom_range(2, 7)) : (clk_b_mon ? 6 : 7);
      end else cnt_b--;
    end
  end

  // Reference model: n counts ref edges since reset; a monitored rise sampled at
  // edge k is acted on at edge k+2; a clock dies 16 edges after its last rise.
  logic [1:0] al_m, alp_m, smp, pend1, pend2;
  logic sel_m, ps_m, p1_m, busy_m, noclk_m, fail_m, want_m;
  int n, last_chg, last_m[2], cnt_m[2];
  assign exp_v = {sel_m, al_m[0], al_m[1], busy_m, noclk_m, fail_m};
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      n = 0; last_chg = -100; last_m = '{0, 0}; cnt_m = '{0, 0};
      al_m = 0; alp_m = 0; smp = 0; pend1 = 0; pend2 = 0;
      sel_m = 0; ps_m = 0; p1_m = 0; busy_m = 0; noclk_m = 1; fail_m = 0;
    end else begin
      n++;
      fail_m  = alp_m[sel_m] & ~al_m[sel_m];
      noclk_m = ~al_m[0] & ~al_m[1];
      want_m  = al_m[ps_m] ? ps_m : al_m[!ps_m] ? !ps_m : sel_m;
      if (n - last_chg >= 9 && want_m != sel_m) begin
        sel_m = want_m;
        last_chg = n;
      end
      busy_m = (n - last_chg) < 8;
      ps_m = p1_m;
      p1_m = pref_sel;
      alp_m = al_m;
      for (int x = 0; x < 2; x++) begin
        if (pend2[x]) begin
          last_m[x] = n;
          if (!al_m[x]) begin
            cnt_m[x]++;
            if (cnt_m[x] == 4) al_m[x] = 1;
          end
        end else if (n - last_m[x] == 16) begin
          al_m[x] = 0;
          cnt_m[x] = 0;
        end
      end
      pend2 = pend1;
      pend1 = {clk_b_mon & ~smp[1], clk_a_mon & ~smp[0]};
      smp = {clk_b_mon, clk_a_mon};
    end
  end

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    tests++;
    if (obs !== 6'b000010) begin fails++; $display("FAIL reset_state got %b exp 000010", obs); end
    @(posedge clk); #2 rst_n = 1;
  endtask

  task automatic test_startup;
    bit a_seen = 0, b_seen = 0, busy_seen = 0;
    ea = 0; eb = 0; pref_sel = 0; run_a = 1; run_b = 1;
    repeat (80) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL startup_model got %b exp %b t=%0t", obs, exp_v, $time); end
      busy_seen |= switch_busy;
      if (a_alive && !a_seen) begin
        a_seen = 1; tests++;
        if (ea !== 4) begin fails++; $display("FAIL startup_a_edges got %0d exp 4", ea); end
      end
      if (b_alive && !b_seen) begin
        b_seen = 1; tests++;
        if (eb !== 4) begin fails++; $display("FAIL startup_b_edges got %0d exp 4", eb); end
      end
    end
    tests++;
    if ({a_alive, b_alive, clk_sel, no_clk, busy_seen} !== 5'b11000) begin
      fails++; $display("FAIL startup_final got %b exp 11000", {a_alive, b_alive, clk_sel, no_clk, busy_seen});
    end
  endtask

  task automatic test_pref_switch;
    int lat = -1, busy_cnt = 0;
    @(negedge clk) pref_sel = 1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL pref_model got %b exp %b t=%0t", obs, exp_v, $time); end
      if (clk_sel && lat < 0) lat = i;
      busy_cnt += int'(switch_busy);
    end
    tests++;
    if (lat < 1 || lat > 4) begin fails++; $display("FAIL pref_latency got %0d exp 1..4", lat); end
    tests++;
    if (busy_cnt !== 8) begin fails++; $display("FAIL pref_busy_len got %0d exp 8", busy_cnt); end
  endtask

  task automatic test_fail_a;
    int fail_cnt = 0, fail_i = -1, sel_i = -1;
    bit dead_seen = 0;
    @(negedge clk) pref_sel = 0;
    repeat (20) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL faila_pre_model got %b exp %b t=%0t", obs, exp_v, $time); end
    end
    tests++;
    if (clk_sel !== 0) begin fails++; $display("FAIL faila_pre_sel got %b exp 0", clk_sel); end
    for (int i = 0; i < 20 && !clk_a_mon; i++) @(posedge clk);
    run_a = 0;
    tests++;
    if (clk_a_mon !== 1) begin fails++; $display("FAIL faila_stop_high got %b exp 1", clk_a_mon); end
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL faila_model got %b exp %b t=%0t", obs, exp_v, $time); end
      if (fail_evt) begin fail_cnt++; if (fail_i < 0) fail_i = i; end
      if (clk_sel && sel_i < 0) sel_i = i;
      if (!a_alive && !dead_seen) begin
        dead_seen = 1; tests++;
        if ($time - last_rise_a !== 190) begin
          fails++; $display("FAIL faila_death_time got %0t exp 190", $time - last_rise_a);
        end
      end
    end
    tests++;
    if (!dead_seen || fail_cnt !== 1) begin fails++; $display("FAIL faila_pulse got %0d exp 1 (dead=%0b)", fail_cnt, dead_seen); end
    tests++;
    if (clk_sel !== 1 || sel_i < fail_i || fail_i < 0) begin
      fails++; $display("FAIL faila_failover got sel=%b sel_i=%0d fail_i=%0d exp sel=1 after pulse", clk_sel, sel_i, fail_i);
    end
  endtask

  task automatic test_pref_toggle;
    int last_i = -100, changes = 0;
    logic prev_sel, prev_busy;
    run_a = 1;
    repeat (60) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL toggle_pre_model got %b exp %b t=%0t", obs, exp_v, $time); end
    end
    prev_sel = clk_sel; prev_busy = switch_busy;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (i % 3 == 0) pref_sel = ~pref_sel;
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL toggle_model got %b exp %b t=%0t", obs, exp_v, $time); end
      if (clk_sel !== prev_sel) begin
        changes++; tests++;
        if (i - last_i < 9 || prev_busy) begin
          fails++; $display("FAIL toggle_spacing got gap %0d busy %b exp >=9 and 0", i - last_i, prev_busy);
        end
        last_i = i;
      end
      prev_sel = clk_sel; prev_busy = switch_busy;
    end
    tests++;
    if (changes < 3) begin fails++; $display("FAIL toggle_changes got %0d exp >=3", changes); end
  endtask

  task automatic test_both_dead;
    logic held;
    @(negedge clk) pref_sel = 0;
    repeat (20) @(negedge clk);
    run_a = 0; run_b = 0;
    repeat (40) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL dead_model got %b exp %b t=%0t", obs, exp_v, $time); end
    end
    tests++;
    if ({no_clk, a_alive, b_alive} !== 3'b100) begin fails++; $display("FAIL dead_noclk got %b exp 100", {no_clk, a_alive, b_alive}); end
    held = clk_sel;
    repeat (30) begin
      @(negedge clk);
      tests++;
      if (clk_sel !== held) begin fails++; $display("FAIL dead_sel_held got %b exp %b", clk_sel, held); end
    end
    run_b = 1;
    repeat (80) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL restart_model got %b exp %b t=%0t", obs, exp_v, $time); end
    end
    tests++;
    if ({b_alive, a_alive, clk_sel, no_clk} !== 4'b1010) begin
      fails++; $display("FAIL restart_b got %b exp 1010", {b_alive, a_alive, clk_sel, no_clk});
    end
  endtask

  task automatic test_reset_hold;
    int exp_edges;
    bit a_seen = 0;
    run_a = 1;
    repeat (60) @(negedge clk);
    for (int i = 0; i < 20 && switch_busy; i++) @(negedge clk);
    pref_sel = ~clk_sel;
    for (int i = 0; i < 10 && !switch_busy; i++) @(negedge clk);
    tests++;
    if (switch_busy !== 1) begin fails++; $display("FAIL rsthold_enter got %b exp 1", switch_busy); end
    @(negedge clk); #2 rst_n = 0;
    #1 tests++;
    if (obs !== 6'b000010) begin fails++; $display("FAIL rsthold_async got %b exp 000010", obs); end
    @(posedge clk); #2 rst_n = 1;
    ea = 0;
    exp_edges = clk_a_mon ? 3 : 4;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL rsthold_model got %b exp %b t=%0t", obs, exp_v, $time); end
      if (i == 6) begin
        tests++;
        if ({a_alive, b_alive} !== 2'b00) begin fails++; $display("FAIL rsthold_requal got %b exp 00", {a_alive, b_alive}); end
      end
      if (a_alive && !a_seen) begin
        a_seen = 1; tests++;
        if (ea !== exp_edges) begin fails++; $display("FAIL rsthold_edges got %0d exp %0d", ea, exp_edges); end
      end
    end
  endtask

  task automatic test_random;
    rnd = 1;
    repeat (2000) begin
      @(negedge clk);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL random_model got %b exp %b t=%0t", obs, exp_v, $time); end
      if ($urandom_range(0, 19) == 0) pref_sel = ~pref_sel;
      if ($urandom_range(0, 149) == 0) run_a = ~run_a;
      if ($urandom_range(0, 149) == 0) run_b = ~run_b;
    end
  endtask

  initial begin
    test_reset;
    test_startup;
    test_pref_switch;
    test_fail_a;
    test_pref_toggle;
    test_both_dead;
    test_reset_hold;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
